// File: rtl/egress_slot_scheduler_if.sv
// Purpose: handshake/data bundle between slot-window logic, the queue servers and the egress scheduler.
// Latency: none, wires only.
// Backpressure: requesters hold req/len until they see their grant; no ready signal.
interface egress_slot_scheduler_if #(
    parameter int N_RC = 2
);
    // slot window and line-time inputs
    logic              tick;
    logic [1:0]        slot_state;
    logic [7:0]        slot_remain;
    // per-class requests
    logic              tt_req;
    logic [7:0]        tt_len;
    logic [N_RC-1:0]   rc_req;
    logic [8*N_RC-1:0] rc_len;
    logic              be_req;
    logic [7:0]        be_len;
    // grants and transmit status
    logic              tt_gnt;
    logic [N_RC-1:0]   rc_gnt;
    logic              be_gnt;
    logic              tx_busy;
    logic [1:0]        tx_class;
    logic [3:0]        tx_chan;
    logic [7:0]        tx_remain;
    logic              tx_done;
    logic              tx_abort;
    logic              overrun;

    // upstream side: drives slot info and requests, receives grants/status
    modport master (
        output tick, slot_state, slot_remain,
        output tt_req, tt_len, rc_req, rc_len, be_req, be_len,
        input  tt_gnt, rc_gnt, be_gnt, tx_busy, tx_class, tx_chan,
        input  tx_remain, tx_done, tx_abort, overrun
    );

    // scheduler side
    modport slave (
        input  tick, slot_state, slot_remain,
        input  tt_req, tt_len, rc_req, rc_len, be_req, be_len,
        output tt_gnt, rc_gnt, be_gnt, tx_busy, tx_class, tx_chan,
        output tx_remain, tx_done, tx_abort, overrun
    );
endinterface

// File: rtl/egress_slot_scheduler.sv
// Purpose: per-port egress scheduler, TT > RC(round-robin) > BE, slot-window admission, 16B-unit tx tracking.
// Latency: grant one cycle after admissible inputs are sampled; L ticks in XMIT plus one gap tick.
// Backpressure: requesters hold req/len until granted; re-arbitration only from IDLE. Macro SLOT_ABORT_EN cuts RC/BE frames hit by a TT slot.
module egress_slot_scheduler #(
    parameter int N_RC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    egress_slot_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] CLS_NONE    = 2'b00;
    localparam logic [1:0] CLS_TT      = 2'b01;
    localparam logic [1:0] CLS_RC      = 2'b10;
    localparam logic [1:0] CLS_BE      = 2'b11;
    localparam logic [1:0] SLOT_DEF    = 2'b00;
    localparam logic [1:0] SLOT_MARGIN = 2'b01;
    localparam logic [1:0] SLOT_TT     = 2'b11;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic              r_tt_gnt, w_tt_gnt_nxt;
    logic [N_RC-1:0]   r_rc_gnt, w_rc_gnt_nxt;
    logic              r_be_gnt, w_be_gnt_nxt;
    logic [1:0]        r_tx_class, w_tx_class_nxt;
    logic [3:0]        r_tx_chan, w_tx_chan_nxt;
    logic [7:0]        r_tx_remain, w_tx_remain_nxt;
    logic              r_tx_done, w_tx_done_nxt;
    logic              r_overrun, w_overrun_nxt;

    logic              w_tt_ok, w_be_ok, w_rc_any, w_any_ok;
    logic [N_RC-1:0]   w_rc_ok;
    logic              w_hi_found, w_lo_found;
    logic [3:0]        w_hi_idx, w_lo_idx, w_rc_idx;
    logic [7:0]        w_hi_len, w_lo_len, w_rc_len;
    logic              w_last_tick, w_guard, w_abort;

    // admissibility of each requester against the current slot window
    always_comb begin
        w_rc_ok = '0;
        w_tt_ok = bus.tt_req && (bus.tt_len != 8'd0) && (bus.slot_state == SLOT_TT)
                  && (bus.tt_len <= bus.slot_remain);
        w_be_ok = bus.be_req && (bus.be_len != 8'd0) && (bus.slot_state == SLOT_DEF);
        for (int i = 0; i < N_RC; i++) begin
            w_rc_ok[i] = bus.rc_req[i] && (bus.rc_len[8*i +: 8] != 8'd0)
                         && ((bus.slot_state == SLOT_DEF)
                             || ((bus.slot_state == SLOT_MARGIN)
                                 && (bus.rc_len[8*i +: 8] <= bus.slot_remain)));
        end
    end

    // round-robin pick: first admissible queue at/after rr_ptr, else first below it (wrap)
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = 4'd0;
        w_lo_idx   = 4'd0;
        w_hi_len   = 8'd0;
        w_lo_len   = 8'd0;
        for (int i = 0; i < N_RC; i++) begin
            if (w_rc_ok[i] && !w_hi_found && (4'(i) >= r_rr_ptr)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = 4'(i);
                w_hi_len   = bus.rc_len[8*i +: 8];
            end
            if (w_rc_ok[i] && !w_lo_found && (4'(i) < r_rr_ptr)) begin
                w_lo_found = 1'b1;
                w_lo_idx   = 4'(i);
                w_lo_len   = bus.rc_len[8*i +: 8];
            end
        end
        w_rc_any = w_hi_found || w_lo_found;
        w_rc_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        w_rc_len = w_hi_found ? w_hi_len : w_lo_len;
        w_any_ok = w_tt_ok || w_rc_any || w_be_ok;
    end

    // A TT slot arriving under an RC/BE frame is a guard violation, unless this
    // very tick finishes the frame.
    assign w_last_tick = bus.tick && (r_tx_remain == 8'd1);
    assign w_guard     = (r_state == S_XMIT)
                         && ((r_tx_class == CLS_RC) || (r_tx_class == CLS_BE))
                         && (bus.slot_state == SLOT_TT) && !w_last_tick;
`ifdef SLOT_ABORT_EN
    assign w_abort = w_guard;
`else
    assign w_abort = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state: leave IDLE on any admissible request, count ticks in XMIT, one gap tick
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any_ok) w_state_nxt = S_XMIT;
            S_XMIT: if (w_abort || w_last_tick) w_state_nxt = S_GAP;
            S_GAP:  if (bus.tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // output/datapath next values: grant pulses, frame descriptor, unit countdown
    always_comb begin
        w_tt_gnt_nxt    = 1'b0;
        w_rc_gnt_nxt    = '0;
        w_be_gnt_nxt    = 1'b0;
        w_tx_done_nxt   = 1'b0;
        w_tx_class_nxt  = r_tx_class;
        w_tx_chan_nxt   = r_tx_chan;
        w_tx_remain_nxt = r_tx_remain;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_overrun_nxt   = r_overrun || w_guard;
        case (r_state)
            S_IDLE: begin
                if (w_tt_ok) begin
                    w_tt_gnt_nxt    = 1'b1;
                    w_tx_class_nxt  = CLS_TT;
                    w_tx_chan_nxt   = 4'd0;
                    w_tx_remain_nxt = bus.tt_len;
                end else if (w_rc_any) begin
                    for (int i = 0; i < N_RC; i++) begin
                        w_rc_gnt_nxt[i] = (w_rc_idx == 4'(i));
                    end
                    w_tx_class_nxt  = CLS_RC;
                    w_tx_chan_nxt   = w_rc_idx;
                    w_tx_remain_nxt = w_rc_len;
                    w_rr_ptr_nxt    = (w_rc_idx == 4'(N_RC - 1)) ? 4'd0 : (w_rc_idx + 4'd1);
                end else if (w_be_ok) begin
                    w_be_gnt_nxt    = 1'b1;
                    w_tx_class_nxt  = CLS_BE;
                    w_tx_chan_nxt   = 4'd0;
                    w_tx_remain_nxt = bus.be_len;
                end
            end
            S_XMIT: begin
                if (w_abort) begin
                    w_tx_remain_nxt = 8'd0;
                    w_tx_class_nxt  = CLS_NONE;
                    w_tx_chan_nxt   = 4'd0;
                end else if (bus.tick) begin
                    w_tx_remain_nxt = r_tx_remain - 8'd1;
                    if (w_last_tick) begin
                        w_tx_done_nxt  = 1'b1;
                        w_tx_class_nxt = CLS_NONE;
                        w_tx_chan_nxt  = 4'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    // output and arbitration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= 4'd0;
            r_tt_gnt    <= 1'b0;
            r_rc_gnt    <= '0;
            r_be_gnt    <= 1'b0;
            r_tx_class  <= CLS_NONE;
            r_tx_chan   <= 4'd0;
            r_tx_remain <= 8'd0;
            r_tx_done   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_tt_gnt    <= w_tt_gnt_nxt;
            r_rc_gnt    <= w_rc_gnt_nxt;
            r_be_gnt    <= w_be_gnt_nxt;
            r_tx_class  <= w_tx_class_nxt;
            r_tx_chan   <= w_tx_chan_nxt;
            r_tx_remain <= w_tx_remain_nxt;
            r_tx_done   <= w_tx_done_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

`ifdef SLOT_ABORT_EN
    logic r_tx_abort;

    // abort pulse accompanies the cut of an RC/BE frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_abort <= 1'b0;
        end else begin
            r_tx_abort <= w_abort;
        end
    end
    assign bus.tx_abort = r_tx_abort;
`else
    assign bus.tx_abort = 1'b0;
`endif

    assign bus.tt_gnt    = r_tt_gnt;
    assign bus.rc_gnt    = r_rc_gnt;
    assign bus.be_gnt    = r_be_gnt;
    assign bus.tx_busy   = (r_state != S_IDLE);
    assign bus.tx_class  = r_tx_class;
    assign bus.tx_chan   = r_tx_chan;
    assign bus.tx_remain = r_tx_remain;
    assign bus.tx_done   = r_tx_done;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_egress_slot_scheduler.sv
// Bench for egress_slot_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_egress_slot_scheduler;
    localparam int N = 2;
`ifdef SLOT_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    egress_slot_scheduler_if #(.N_RC(N)) bus ();

    egress_slot_scheduler #(.N_RC(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model: frame in flight, units left, gap pending, RR pointer, sticky overrun
    bit       m_xmit, m_gap, m_over;
    int       m_cls, m_chan, m_rem, m_rr;
    bit       e_tt, e_be, e_done, e_abort;
    logic [N-1:0] e_rc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit tt_fits();
        return bus.tt_req && bus.tt_len != 0 && bus.slot_state == 2'b11 && bus.tt_len <= bus.slot_remain;
    endfunction

    function automatic bit rc_fits(input int q);
        int len;
        len = int'(bus.rc_len[8*q +: 8]);
        if (!bus.rc_req[q] || len == 0) return 1'b0;
        if (bus.slot_state == 2'b00) return 1'b1;
        return bus.slot_state == 2'b01 && len <= int'(bus.slot_remain);
    endfunction

    function automatic bit be_fits();
        return bus.be_req && bus.be_len != 0 && bus.slot_state == 2'b00;
    endfunction

    task automatic start_frame(input int cls, input int chan, input int len);
        m_xmit = 1'b1;
        m_cls  = cls;
        m_chan = chan;
        m_rem  = len;
    endtask

    task automatic end_frame();
        m_xmit = 1'b0;
        m_gap  = 1'b1;
        m_cls  = 0;
        m_chan = 0;
        m_rem  = 0;
    endtask

    // predicts the outcome of the coming clock edge from the inputs now applied
    task automatic model_step();
        e_tt = 0; e_rc = '0; e_be = 0; e_done = 0; e_abort = 0;
        if (rst) begin
            m_xmit = 0; m_gap = 0; m_over = 0;
            m_cls = 0; m_chan = 0; m_rem = 0; m_rr = 0;
        end else if (m_xmit) begin
            bit last, viol;
            last = bus.tick && m_rem == 1;
            viol = (m_cls == 2 || m_cls == 3) && bus.slot_state == 2'b11 && !last;
            if (viol) m_over = 1'b1;
            if (viol && ABORT) begin
                e_abort = 1'b1;
                end_frame();
            end else if (bus.tick) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    e_done = 1'b1;
                    end_frame();
                end
            end
        end else if (m_gap) begin
            if (bus.tick) m_gap = 1'b0;
        end else begin
            int win;
            win = -1;
            for (int k = 0; k < N; k++) begin
                int q;
                q = (m_rr + k) % N;
                if (win < 0 && rc_fits(q)) win = q;
            end
            if (tt_fits()) begin
                e_tt = 1'b1;
                start_frame(1, 0, int'(bus.tt_len));
            end else if (win >= 0) begin
                e_rc[win] = 1'b1;
                start_frame(2, win, int'(bus.rc_len[8*win +: 8]));
                m_rr = (win + 1) % N;
            end else if (be_fits()) begin
                e_be = 1'b1;
                start_frame(3, 0, int'(bus.be_len));
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("tt_gnt",    bus.tt_gnt,    e_tt);
        chk("rc_gnt",    bus.rc_gnt,    e_rc);
        chk("be_gnt",    bus.be_gnt,    e_be);
        chk("tx_busy",   bus.tx_busy,   m_xmit || m_gap);
        chk("tx_class",  bus.tx_class,  m_cls);
        chk("tx_chan",   bus.tx_chan,   m_chan);
        chk("tx_remain", bus.tx_remain, m_rem);
        chk("tx_done",   bus.tx_done,   e_done);
        chk("tx_abort",  bus.tx_abort,  e_abort);
        chk("overrun",   bus.overrun,   m_over);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.tick = 1'b1;
        while (bus.tx_busy && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_idle", bus.tx_busy, 0);
        bus.tick = 1'b0;
    endtask

    logic [N-1:0] rr_gnt_exp [3];
    int           rr_chan_exp[3];

    initial begin
        rr_gnt_exp  = '{2'b01, 2'b10, 2'b01};
        rr_chan_exp = '{0, 1, 0};
        bus.tick = 0; bus.slot_state = 2'b00; bus.slot_remain = 0;
        bus.tt_req = 0; bus.tt_len = 0; bus.rc_req = '0; bus.rc_len = '0;
        bus.be_req = 0; bus.be_len = 0;

        // reset values
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_class", bus.tx_class, 0);
        chk("rst_remain", bus.tx_remain, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        cycle();

        // TT grant, 4 units, done on 4th tick, idle after 5th
        bus.slot_state = 2'b11; bus.slot_remain = 8'd28;
        bus.tt_req = 1'b1; bus.tt_len = 8'd4;
        cycle();
        chk("tt_gnt_pulse", bus.tt_gnt, 1);
        chk("tt_class", bus.tx_class, 2'b01);
        chk("tt_remain", bus.tx_remain, 4);
        bus.tt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.tick = 1'b1;
            cycle();
        end
        chk("tt_done", bus.tx_done, 1);
        chk("tt_gap_busy", bus.tx_busy, 1);
        cycle();
        chk("tt_idle", bus.tx_busy, 0);
        bus.tick = 1'b0;

        // RC round-robin with both queues held
        bus.slot_state = 2'b00;
        bus.rc_req = 2'b11; bus.rc_len = {8'd2, 8'd2};
        bus.tick = 1'b1;
        for (int g = 0; g < 3; g++) begin
            int n;
            n = 0;
            do begin
                cycle();
                n++;
            end while (bus.rc_gnt == '0 && n < 20);
            chk("rr_gnt", bus.rc_gnt, rr_gnt_exp[g]);
            chk("rr_chan", bus.tx_chan, rr_chan_exp[g]);
        end
        bus.rc_req = '0;
        drain();

        // margin slot: length must fit, BE never admitted
        bus.slot_state = 2'b01; bus.slot_remain = 8'd5;
        bus.rc_req = 2'b01; bus.rc_len = {8'd0, 8'd6};
        bus.be_req = 1'b1; bus.be_len = 8'd3;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("margin_no_rc", bus.rc_gnt, 0);
            chk("margin_no_be", bus.be_gnt, 0);
        end
        bus.rc_len = {8'd0, 8'd5};
        cycle();
        chk("margin_fit_gnt", bus.rc_gnt, 2'b01);
        bus.rc_req = '0;
        drain();
        for (int i = 0; i < 3; i++) cycle();
        bus.be_req = 1'b0;

        // PCF blocks everything; TT slot then grants TT over RC/BE
        bus.slot_state = 2'b10; bus.slot_remain = 8'd28;
        bus.tt_req = 1'b1; bus.tt_len = 8'd3;
        bus.rc_req = 2'b11; bus.rc_len = {8'd2, 8'd2};
        bus.be_req = 1'b1; bus.be_len = 8'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("pcf_no_gnt", {bus.tt_gnt, bus.rc_gnt, bus.be_gnt}, 0);
        end
        bus.slot_state = 2'b11;
        cycle();
        chk("prio_tt", bus.tt_gnt, 1);
        chk("prio_no_rc_be", {bus.rc_gnt, bus.be_gnt}, 0);
        bus.tt_req = 0; bus.rc_req = '0; bus.be_req = 0;
        drain();

        // guard violation: BE length 10, TT slot after 3 ticks
        bus.slot_state = 2'b00;
        bus.be_req = 1'b1; bus.be_len = 8'd10;
        cycle();
        chk("guard_be_gnt", bus.be_gnt, 1);
        bus.be_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tick = 1'b1;
            cycle();
        end
        bus.tick = 1'b0;
        bus.slot_state = 2'b11;
        cycle();
        chk("guard_overrun", bus.overrun, 1);
        if (ABORT) begin
            chk("guard_abort", bus.tx_abort, 1);
            chk("guard_abort_remain", bus.tx_remain, 0);
        end else begin
            chk("guard_continue_remain", bus.tx_remain, 7);
            for (int i = 0; i < 7; i++) begin
                bus.tick = 1'b1;
                cycle();
            end
            chk("guard_done_tick10", bus.tx_done, 1);
        end
        drain();
        bus.slot_state = 2'b00;

        // reset in the middle of a frame
        bus.be_req = 1'b1; bus.be_len = 8'd9;
        cycle();
        bus.be_req = 1'b0;
        bus.tick = 1'b1;
        cycle();
        cycle();
        chk("mid_remain7", bus.tx_remain, 7);
        rst = 1'b1;
        cycle();
        chk("mid_rst_busy", bus.tx_busy, 0);
        chk("mid_rst_done", bus.tx_done, 0);
        chk("mid_rst_remain", bus.tx_remain, 0);
        chk("mid_rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        bus.tick = 1'b0;
        bus.rc_req = 2'b11; bus.rc_len = {8'd1, 8'd1};
        cycle();
        chk("mid_rst_rr0", bus.rc_gnt, 2'b01);
        bus.rc_req = '0;
        drain();

        // random traffic obeying the requester contract
        for (int c = 0; c < 1500; c++) begin
            if (e_tt) bus.tt_req = 1'b0;
            if (e_be) bus.be_req = 1'b0;
            for (int q = 0; q < N; q++) if (e_rc[q]) bus.rc_req[q] = 1'b0;
            if (!bus.tt_req && $urandom_range(3) == 0) begin
                bus.tt_req = 1'b1;
                bus.tt_len = 8'($urandom_range(1, 12));
            end
            for (int q = 0; q < N; q++) begin
                if (!bus.rc_req[q] && $urandom_range(2) == 0) begin
                    bus.rc_req[q] = 1'b1;
                    bus.rc_len[8*q +: 8] = 8'($urandom_range(1, 12));
                end
            end
            if (!bus.be_req && $urandom_range(3) == 0) begin
                bus.be_req = 1'b1;
                bus.be_len = 8'($urandom_range(1, 12));
            end
            bus.tick = 1'($urandom_range(1));
            if ($urandom_range(9) == 0) begin
                bus.slot_state  = 2'($urandom_range(3));
                bus.slot_remain = 8'($urandom_range(20));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/egress_slot_scheduler.md
# egress_slot_scheduler

Per-port egress scheduler that sits between the timetable/window translation logic and the per-class queue servers. It decides each frame start by strict priority (TT > RC > BE) with round-robin among RC queues, admits a frame only if it fits the current slot window, and grants the winning queue. It then tracks the frame's transmission in 16-byte units and enforces a one-unit inter-frame gap. It also flags or aborts RC/BE frames that run into a TT slot.

## Interface
- `N_RC`, default 2: number of RC queues, 1..16.
- `clk` input 1: single clock.
- `rst` input 1: synchronous reset, active-high.
- `tick` input 1: one-cycle pulse per 16-byte line time.
- `slot_state` input 2: current slot type. 00 default, 01 margin, 11 TT, 10 PCF.
- `slot_remain` input 8: remaining slot length, in 16-byte units.
- `tt_req` input 1: TT frame pending.
- `tt_len` input 8: length of the TT frame.
- `rc_req` input N_RC: RC frame pending, one bit per queue.
- `rc_len` input 8*N_RC: RC frame lengths; queue i uses bits [8i+7:8i].
- `be_req` input 1: BE frame pending.
- `be_len` input 8: length of the BE frame.
- `tt_gnt` output 1: one-cycle grant pulse to the TT queue.
- `rc_gnt` output N_RC: one-hot, one-cycle grant pulse to an RC queue.
- `be_gnt` output 1: one-cycle grant pulse to the BE queue.
- `tx_busy` output 1: high in XMIT and GAP.
- `tx_class` output 2: class in flight. 00 none, 01 TT, 10 RC, 11 BE.
- `tx_chan` output 4: RC index of the frame in flight, else 0.
- `tx_remain` output 8: units left of the frame in flight.
- `tx_done` output 1: one-cycle pulse when a frame completes.
- `tx_abort` output 1: one-cycle pulse when a frame is aborted. Stuck at 0 when abort is compiled out.
- `overrun` output 1: sticky; a guard violation occurred.

## Operation
- **Lengths:** in 16-byte units. A request with length 0 is never admissible.
- **Admissibility:**
  - TT: `slot_state`=11 and `tt_len` ≤ `slot_remain`.
  - RC: `slot_state`=00, or `slot_state`=01 and `rc_len` ≤ `slot_remain`.
  - BE: `slot_state`=00 only.
  - PCF slot: nothing is admissible.
- **Priority:** TT first, then RC, then BE.
  - Among admissible RC queues, pick the first at or after `rr_ptr`, wrapping from N_RC-1 to 0.
  - On each RC grant, `rr_ptr` becomes (granted index + 1) mod N_RC. Other grants leave it unchanged.
- **FSM states:** IDLE, XMIT, GAP.
  - IDLE → XMIT on any clock edge with an admissible request; `tick` is not required. That edge registers:
    - the grant pulse;
    - `tx_class` and `tx_chan`;
    - `tx_remain` = granted length.
  - XMIT: on each `tick`, `tx_remain` decrements by 1. A tick with `tx_remain`=1 sets `tx_remain` to 0, pulses `tx_done`, and enters GAP.
  - GAP: `tx_class` is already 00. The next `tick` returns to IDLE.
  - `tick` is ignored in IDLE.
- **Requester contract:**
  - Hold `req` and `len` stable until the grant is seen.
  - Deassert `req` in the cycle after the grant, or present the next frame.
  - The scheduler re-arbitrates only from IDLE.
- **Guard violation:** `slot_state` becomes 11 while in XMIT with `tx_class` RC or BE.
  - `overrun` is set and stays set until `rst`.
  - Whether the frame continues depends on the configuration below.
- **TT in flight:** a TT frame is never interrupted. A slot change during a TT frame has no effect on it.

## Timing
- **Reset values:** state IDLE, `rr_ptr`=0. All grants, `tx_busy`, `tx_class`, `tx_chan`, `tx_remain`, `tx_done`, `tx_abort` and `overrun` are 0.
- **Grant latency:** the grant is asserted one cycle after the admissible inputs are sampled. `tx_busy` rises in the same cycle as the grant.
- **Occupancy:** a length-L frame occupies XMIT for L ticks, then GAP for 1 tick. The earliest next grant is in the cycle after the gap tick's edge.
- **Simultaneous events:**
  - `tick` on the same edge as a grant is not counted.
  - `tick` together with a `slot_state` change on the last unit: the frame completes with `tx_done`, and no overrun is flagged.
- **Reset during operation:** `rst` in any state forces the reset values on the next edge. No `tx_done` or `tx_abort` is emitted.

## Configuration
- **`SLOT_ABORT_EN` defined:** on a guard violation the RC/BE frame is cut.
  - Next edge: `tx_abort` pulses, `tx_remain` becomes 0, the FSM enters GAP, and `overrun` is set.
  - No `tx_done` is emitted for the aborted frame.
- **`SLOT_ABORT_EN` undefined:** the frame runs to completion with a normal `tx_done`. Only `overrun` is set, and `tx_abort` is tied to 0.

## Test plan
- **TT grant:** `slot_state`=11, `slot_remain`=28, `tt_req` with `tt_len`=4.
  - `tt_gnt` pulses 1 cycle later, with `tx_class`=01 and `tx_remain`=4.
  - `tx_done` follows the 4th tick; return to IDLE after the 5th tick.
- **RC round-robin:** `slot_state`=00, `N_RC`=2, both `rc_req` held with `rc_len`=2.
  - Grants alternate rc_gnt=01, 10, 01; `tx_chan` follows as 0, 1, 0.
- **Margin fit:** `slot_state`=01, `slot_remain`=5, `rc_len`=6, then 5.
  - No grant while `rc_len`=6; grant once `rc_len`=5.
  - BE is never granted in this slot.
- **Priority and PCF block:** `slot_state`=10 with all requests pending → no grant.
  - Switch to 11 with all pending → `tt_gnt`, not RC or BE.
- **Guard violation:** `slot_state` 00→11 after 3 ticks of a BE frame with length 10.
  - With `SLOT_ABORT_EN`: `tx_abort` and `overrun`=1, then GAP.
  - Without it: `overrun`=1 and `tx_done` after tick 10.
- **Reset mid-frame:** `rst`=1 during XMIT with `tx_remain`=7 → all outputs 0 next cycle, `rr_ptr`=0, with no `tx_done`.
